// File: rtl/tl_a_arbiter_if.sv
// -----------------------------------------------------------------------------
// tl_a_arbiter_if
//
// One TileLink-UL link: A channel (request) plus D channel (response).
//
// Modports:
//   master : drives a_valid/a_opcode/a_size/a_source/a_payload and d_ready;
//            receives a_ready and the d_* response fields.
//   slave  : the opposite side of the same link.
//
// Parameters:
//   SRC_W  width of a_source / d_source
//   PAY_W  width of the opaque A payload (param, address, mask, data)
//   D_W    width of d_data
// -----------------------------------------------------------------------------
interface tl_a_arbiter_if #(
    parameter int SRC_W = 2,
    parameter int PAY_W = 73,
    parameter int D_W   = 32
);
    logic             a_valid;
    logic             a_ready;
    logic [2:0]       a_opcode;
    logic [2:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [PAY_W-1:0] a_payload;

    logic             d_valid;
    logic             d_ready;
    logic [2:0]       d_opcode;
    logic [2:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic [D_W-1:0]   d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_payload, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_payload, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_data
    );
endinterface

// File: rtl/tl_a_arbiter.sv
// -----------------------------------------------------------------------------
// tl_a_arbiter
//
// Two-requester TileLink-UL A-channel arbiter in front of one downstream port.
// Round-robin between requesters; the grant is locked while an offered beat
// stalls (HOLD) and for the remaining beats of a multi-beat burst (BURST).
// The winning requester index is prepended as the MSB of out.a_source, and
// the D channel is steered back on that same bit.
//
// Ports:
//   clock  in   clock
//   reset  in   synchronous active-high reset
//   in0    slave  modport, requester 0 (a_source/d_source SRC_W bits)
//   in1    slave  modport, requester 1
//   out    master modport, downstream port (a_source/d_source SRC_W+1 bits)
//
// Optional feature (macro TL_ARB_OUTSTANDING_LIMIT_EN):
//   per-requester outstanding counters; a requester with MAX_OUT requests in
//   flight is skipped by IDLE arbitration and sees a_ready=0.
// -----------------------------------------------------------------------------
module tl_a_arbiter #(
    parameter int SRC_W    = 2,
    parameter int PAY_W    = 73,
    parameter int D_W      = 32,
    parameter int BEAT_LG  = 2,
    parameter int MAX_SIZE = 6,
    parameter int MAX_OUT  = 4
) (
    input  logic           clock,
    input  logic           reset,
    tl_a_arbiter_if.slave  in0,
    tl_a_arbiter_if.slave  in1,
    tl_a_arbiter_if.master out
);

    localparam logic [2:0] BEAT_LG_3  = 3'(BEAT_LG);
    localparam logic [2:0] MAX_SIZE_3 = 3'(MAX_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_BURST
    } state_e;

    // Beats in a request/response of 2^size bytes. Sizes beyond MAX_SIZE are
    // illegal; clamping them keeps the 4-bit beat counter from wrapping.
    function automatic logic [4:0] beats_of(input logic       multi,
                                            input logic [2:0] size);
        logic [2:0] sz;
        sz = (size > MAX_SIZE_3) ? MAX_SIZE_3 : size;
        if (multi && (sz > BEAT_LG_3)) begin
            return 5'd1 << (sz - BEAT_LG_3);
        end
        return 5'd1;
    endfunction

    state_e     state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       rr_last_q, rr_last_d;
    logic [3:0] beats_left_q, beats_left_d;

    // Requester-side A fields gathered into arrays so selection is a mux.
    logic [1:0]       in_valid;
    logic [2:0]       in_opcode  [2];
    logic [2:0]       in_size    [2];
    logic [SRC_W-1:0] in_source  [2];
    logic [PAY_W-1:0] in_payload [2];

    assign in_valid      = {in1.a_valid, in0.a_valid};
    assign in_opcode[0]  = in0.a_opcode;
    assign in_opcode[1]  = in1.a_opcode;
    assign in_size[0]    = in0.a_size;
    assign in_size[1]    = in1.a_size;
    assign in_source[0]  = in0.a_source;
    assign in_source[1]  = in1.a_source;
    assign in_payload[0] = in0.a_payload;
    assign in_payload[1] = in1.a_payload;

    logic [1:0] at_limit;   // requester has MAX_OUT requests in flight
    logic [1:0] eligible;   // may win IDLE arbitration
    logic       sel;        // requester currently forwarded downstream
    logic       a_valid_c;
    logic [1:0] a_ready_c;
    logic       a_fire;
    logic [4:0] sel_beats;

    assign eligible = in_valid & ~at_limit;

    // In IDLE prefer the requester that did not win last; once locked the
    // grant register alone decides.
    always_comb begin
        sel = gnt_q;
        if (state_q == ST_IDLE) begin
            sel = eligible[~rr_last_q] ? ~rr_last_q : rr_last_q;
        end
    end

    // NOTE: every signal assigned in an always_comb gets a default at the
    // top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_valid_c = 1'b0;
        a_ready_c = 2'b00;
        if (!reset) begin
            if (state_q == ST_IDLE) begin
                a_valid_c      = eligible[sel];
                a_ready_c[sel] = out.a_ready & ~at_limit[sel];
            end else begin
                a_valid_c      = in_valid[sel];
                a_ready_c[sel] = out.a_ready;
            end
        end
    end

    assign a_fire    = a_valid_c & out.a_ready;
    assign sel_beats = beats_of(in_opcode[sel] <= 3'd3, in_size[sel]);

    assign out.a_valid   = a_valid_c;
    assign out.a_opcode  = in_opcode[sel];
    assign out.a_size    = in_size[sel];
    assign out.a_source  = {sel, in_source[sel]};
    assign out.a_payload = in_payload[sel];
    assign in0.a_ready   = a_ready_c[0];
    assign in1.a_ready   = a_ready_c[1];

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_last_d    = rr_last_q;
        beats_left_d = beats_left_q;
        case (state_q)
            // HOLD shares IDLE's transitions: there sel is already gnt_q.
            ST_IDLE, ST_HOLD: begin
                if (a_fire) begin
                    rr_last_d = sel;
                    gnt_d     = sel;
                    if (sel_beats > 5'd1) begin
                        state_d      = ST_BURST;
                        beats_left_d = 4'(sel_beats - 5'd1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (a_valid_c) begin
                    state_d = ST_HOLD;
                    gnt_d   = sel;
                end
            end
            ST_BURST: begin
                // Bubbles simply leave the lock in place.
                if (a_fire) begin
                    beats_left_d = beats_left_q - 4'd1;
                    if (beats_left_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 1'b0;
            rr_last_q    <= 1'b1;   // requester 0 wins the first arbitration
            beats_left_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_last_q    <= rr_last_d;
            beats_left_q <= beats_left_d;
        end
    end

    // D channel: stateless per beat, steered by the source MSB.
    logic d_idx;
    assign d_idx = out.d_source[SRC_W];

    assign in0.d_valid  = out.d_valid & ~d_idx;
    assign in1.d_valid  = out.d_valid &  d_idx;
    assign in0.d_opcode = out.d_opcode;
    assign in1.d_opcode = out.d_opcode;
    assign in0.d_size   = out.d_size;
    assign in1.d_size   = out.d_size;
    assign in0.d_source = out.d_source[SRC_W-1:0];
    assign in1.d_source = out.d_source[SRC_W-1:0];
    assign in0.d_data   = out.d_data;
    assign in1.d_data   = out.d_data;
    assign out.d_ready  = ~reset & (d_idx ? in1.d_ready : in0.d_ready);

`ifdef TL_ARB_OUTSTANDING_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic       d_fire;
    logic       a_first;    // first beat of a request is accepted
    logic [4:0] d_beats;

    assign d_fire  = out.d_valid & out.d_ready;
    assign a_first = a_fire & (state_q != ST_BURST);
    // Only AccessAckData (opcode 1) can span several D beats.
    assign d_beats = beats_of(out.d_opcode == 3'd1, out.d_size);

    for (genvar k = 0; k < 2; k++) begin : g_outstanding
        logic [CNT_W-1:0] cnt_q;
        logic [3:0]       d_beat_q;
        logic             d_mine, d_last, inc, dec;

        assign d_mine       = d_fire & (d_idx == 1'(k));
        assign d_last       = ({1'b0, d_beat_q} == (d_beats - 5'd1));
        assign inc          = a_first & (sel == 1'(k));
        assign dec          = d_mine & d_last;
        assign at_limit[k]  = (cnt_q == CNT_W'(MAX_OUT));

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q    <= '0;
                d_beat_q <= '0;
            end else begin
                if (inc && !dec) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if (dec && !inc) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                if (d_mine) begin
                    d_beat_q <= d_last ? 4'd0 : d_beat_q + 4'd1;
                end
            end
        end
    end
`else
    assign at_limit = 2'b00;
`endif

endmodule

// File: doc/tl_a_arbiter.md
Name: tl_a_arbiter

Overview:
- Two-requester TileLink-UL A-channel arbiter sharing one downstream port; the D channel is routed back to the requesters.
- Round-robin grant. Grant is locked while an offered beat stalls and for the whole of a multi-beat burst.
- Requester index is appended as the MSB of the outgoing source; the D channel is demultiplexed on that bit.
- Sits between the core-side masters and the TL monitor/crossbar port.

Parameters:
- SRC_W, 2, width of each requester's a/d source field.
- PAY_W, 73, opaque A payload width (param, address, mask, data), passed through unchanged.
- D_W, 32, D data width.
- BEAT_LG, 2, log2 of beat bytes.
- MAX_SIZE, 6, largest legal lg2 transfer size.
- MAX_OUT, 4, per-requester outstanding limit; used only with the optional feature.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- inK_a_valid  in  1  K=0,1, request valid
- inK_a_ready  out  1  request ready
- inK_a_opcode  in  3  TL opcode
- inK_a_size  in  3  lg2 bytes
- inK_a_source  in  SRC_W  source id
- inK_a_payload  in  PAY_W  opaque fields
- out_a_valid  out  1  downstream valid
- out_a_ready  in  1  downstream ready
- out_a_opcode  out  3  opcode
- out_a_size  out  3  size
- out_a_source  out  SRC_W+1  {grant index, inK_a_source}
- out_a_payload  out  PAY_W  payload
- out_d_valid  in  1  response valid
- out_d_ready  out  1  response ready
- out_d_opcode  in  3  response opcode
- out_d_size  in  3  response size
- out_d_source  in  SRC_W+1  response source
- out_d_data  in  D_W  response data
- inK_d_valid  out  1  routed response valid
- inK_d_ready  in  1  routed response ready
- inK_d_opcode  out  3  response opcode
- inK_d_size  out  3  response size
- inK_d_source  out  SRC_W  response source, MSB stripped
- inK_d_data  out  D_W  response data

Behaviour:
- Beats of an A request:
  - 2^(size-BEAT_LG) if opcode is 0..3 (PutFull, PutPartial, Arithmetic, Logical) and size>BEAT_LG.
  - Otherwise 1.
  - Beat counter is 4 bits.
- States: IDLE, HOLD, BURST. Registers: state, gnt (1b), rr_last (1b), beats_left (4b).
- Reset: state=IDLE, rr_last=1 (requester 0 wins first), beats_left=0, gnt=0.
- All outputs are combinational from state and inputs. In reset, out_a_valid=0, all inK_a_ready=0 and out_d_ready=0.
- IDLE:
  - sel = the valid requester other than rr_last if it is valid, else the valid one.
  - out_a_* = in[sel]; in[sel]_a_ready=out_a_ready; the other ready=0.
  - Fire with beats>1: state=BURST, gnt=sel, beats_left=beats-1, rr_last=sel.
  - Fire with beats==1: stay IDLE, rr_last=sel.
  - Valid without ready: state=HOLD, gnt=sel.
- HOLD:
  - Forward only in[gnt]; the other requester cannot steal the grant.
  - Fire: rr_last=gnt; state=BURST if beats>1 (beats_left=beats-1), else IDLE.
- BURST:
  - Forward only in[gnt].
  - Each fire decrements beats_left; fire at beats_left==1 returns to IDLE.
  - Bubbles (in[gnt] not valid) are allowed and do not release the lock.
- Zero-bubble: a back-to-back new grant is allowed in the cycle after a final beat.
- D channel is stateless per beat:
  - idx = out_d_source[SRC_W].
  - in[idx]_d_valid = out_d_valid; out_d_ready = in[idx]_d_ready.
  - The other inK_d_valid=0.
- Simultaneous A and D fires are independent.
- Reset mid-burst returns to IDLE next cycle and discards beats_left.

Optional Feature:
- Macro: TL_ARB_OUTSTANDING_LIMIT_EN.
- When defined:
  - Each requester has an outstanding counter. It increments on the first A beat of a request and decrements on the last D beat.
  - D last beat: opcode AccessAckData(1) with size>BEAT_LG ends on its 2^(size-BEAT_LG)-th beat, tracked by a per-requester D beat counter; all other responses are single-beat.
  - Same-cycle increment and decrement leave the count unchanged.
  - A requester whose count equals MAX_OUT is excluded from IDLE selection and sees inK_a_ready=0. It is never excluded once in HOLD or BURST.
  - Counters reset to 0.
- When undefined: no counters; arbitration is as above.

Test Plan:
- Both request Get size 2 continuously with out_a_ready=1 → grants alternate 0,1,0,1; out_a_source MSB toggles every cycle.
- in0 PutFull size 4 (4 beats), in1 Get valid throughout → 4 consecutive in0 beats, then in1 on cycle 5; beat 3 stalled one cycle by out_a_ready=0 still holds the lock.
- in1 Get alone, out_a_ready=0 for 3 cycles, in0 raises valid on cycle 2 → out_a_source/payload stable from in1 until fire; in0 served next.
- out_d AccessAckData size 3, source 3'b101 → two beats on in1_d with source 2'b01; in0_d_valid stays 0; in1_d_ready=0 back-pressures out_d_ready.
- Reset asserted during beat 2 of a 4-beat burst → next cycle IDLE, requester 0 has priority, no stale lock.
- With TL_ARB_OUTSTANDING_LIMIT_EN, MAX_OUT=4: in0 issues 4 Gets with no D → in0_a_ready=0 and in1 is served; one AccessAckData to in0 → in0 is eligible the next cycle.
